// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared AXI4-Lite response codes, responder FSM states and LFSR constants
// for the instruction SRAM responder.
package ysyx_22050019_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Galois form of x^8+x^6+x^5+x^4+1 for a right-shifting register
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/ysyx_22050019_lfsr8.sv
// 8-bit Galois LFSR used for random read latency when
// YSYX_22050019_ISRAM_RAND_LAT_EN is defined; advances once per step.
module ysyx_22050019_lfsr8
  import ysyx_22050019_axi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [7:0] value
);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      value <= LFSR_SEED;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/ysyx_22050019_isram_rsp.sv
// AXI4-Lite read responder for instruction fetch with modelled memory latency.
// Optional YSYX_22050019_ISRAM_RAND_LAT_EN adds LFSR-driven extra latency.
module ysyx_22050019_isram_rsp
  import ysyx_22050019_axi_pkg::*;
#(
  parameter int unsigned           ADDR_W = 64,
  parameter int unsigned           DATA_W = 32,
  parameter logic [ADDR_W-1:0]     BASE   = ADDR_W'(64'h8000_0000),
  parameter logic [ADDR_W-1:0]     SIZE   = ADDR_W'(64'h0800_0000),
  parameter int unsigned           LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef YSYX_22050019_ISRAM_RAND_LAT_EN
  localparam int unsigned CNT_W = 5;
`else
  localparam int unsigned CNT_W = 4;
`endif

  // Window bounds carried one bit wider so BASE+SIZE cannot wrap
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE};
  localparam logic [ADDR_W:0] WIN_HI = {1'b0, BASE} + {1'b0, SIZE};

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          code_q;
  logic [1:0]          dec_code;
  logic [ADDR_W:0]     addr_ext;
  logic [CNT_W-1:0]    lat_eff;

  // Response code for the address currently on the AR channel
  always_comb begin
    dec_code = RESP_OKAY;
    addr_ext = {1'b0, s_axi_araddr};
    if (s_axi_araddr[1:0] != 2'b00) begin
      dec_code = RESP_SLVERR;
    end else if ((addr_ext < WIN_LO) || (addr_ext >= WIN_HI)) begin
      dec_code = RESP_DECERR;
    end
  end

`ifdef YSYX_22050019_ISRAM_RAND_LAT_EN
  logic       ar_hs;
  logic [7:0] lfsr_value;

  assign ar_hs = (state == IDLE) && s_axi_arready && s_axi_arvalid;

  ysyx_22050019_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (ar_hs),
    .value (lfsr_value)
  );

  assign lat_eff = CNT_W'(LAT) + CNT_W'(lfsr_value[2:0]);
`else
  assign lat_eff = CNT_W'(LAT);
`endif

  // mem_ren is raised one edge early so it is high exactly during the
  // cycle in which the last wait count reaches zero and data is sampled.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      code_q        <= RESP_OKAY;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      mem_ren       <= 1'b0;
      mem_raddr     <= '0;
    end else begin
      mem_ren <= 1'b0;
      case (state)
        IDLE: begin
          if (!s_axi_arready) begin
            s_axi_arready <= 1'b1;
          end else if (s_axi_arvalid) begin
            addr_q        <= s_axi_araddr;
            code_q        <= dec_code;
            cnt           <= lat_eff;
            s_axi_arready <= 1'b0;
            state         <= WAIT;
            if ((dec_code == RESP_OKAY) && (lat_eff == '0)) begin
              mem_ren   <= 1'b1;
              mem_raddr <= s_axi_araddr;
            end
          end
        end

        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            if ((cnt == CNT_W'(1)) && (code_q == RESP_OKAY)) begin
              mem_ren   <= 1'b1;
              mem_raddr <= addr_q;
            end
          end else begin
            s_axi_rdata  <= (code_q == RESP_OKAY) ? mem_rdata : '0;
            s_axi_rresp  <= code_q;
            s_axi_rvalid <= 1'b1;
            state        <= RESP;
          end
        end

        RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_isram_rsp.sv
// Self-checking bench for ysyx_22050019_isram_rsp: directed cases plus
// randomized reads compared against a behavioural memory/response model.
module tb_ysyx_22050019_isram_rsp;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 32;
  localparam logic [63:0] BASE   = 64'h8000_0000;
  localparam logic [63:0] SIZE   = 64'h0800_0000;
  localparam int unsigned LAT    = 1;

  logic              clk;
  logic              rst_n;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  int n_cmp;
  int n_bad;

  logic [31:0] mem [64];

  ysyx_22050019_isram_rsp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BASE   (BASE),
    .SIZE   (SIZE),
    .LAT    (LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_araddr  (araddr),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .mem_ren       (mem_ren),
    .mem_raddr     (mem_raddr),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: 64 real words at BASE, a hash of the address elsewhere
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    if ((a >= BASE) && (off < 64'd256)) return mem[off[7:2]];
    return a[31:0] ^ 32'hA5A5_5A5A;
  endfunction

  assign mem_rdata = mem_word(mem_raddr);

  function automatic logic [1:0] exp_resp(input logic [63:0] a);
    if (a[1:0] != 2'b00) return 2'b10;
    if ((a < BASE) || (a >= BASE + SIZE)) return 2'b11;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One full read: AR handshake, latency/mem strobe checks, optional R stall
  task automatic do_read(input logic [63:0] a, input int hold, input bit early);
    logic [1:0]  er;
    logic [31:0] ed;
    int          i;
    int          ren_cnt;
    int          ren_i;
    logic [63:0] ren_addr;
    bit          ar_bad;
    er = exp_resp(a);
    ed = (er == 2'b00) ? mem_word(a) : 32'h0;
    @(negedge clk);
    arvalid = 1'b1;
    araddr  = a;
    rready  = 1'b0;
    for (int k = 0; k < 20 && !arready; k++) @(negedge clk);
    chk("arready_wait", 64'(arready), 64'd1);
    if (!arready) begin
      arvalid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    araddr  = {$urandom, $urandom};
    if (early) rready = 1'b1;
    ren_cnt  = 0;
    ren_i    = -1;
    ren_addr = '0;
    ar_bad   = 1'b0;
    for (i = 0; i <= 40; i++) begin
      if (rvalid) break;
      if (mem_ren) begin
        ren_cnt++;
        ren_i    = i;
        ren_addr = mem_raddr;
      end
      if (arready) ar_bad = 1'b1;
      @(negedge clk);
    end
    chk("rvalid_seen", 64'(rvalid), 64'd1);
    chk("latency", 64'(i), 64'(LAT + 1));
    chk("arready_low_wait", 64'(ar_bad), 64'd0);
    chk("mem_ren_pulses", 64'(ren_cnt), (er == 2'b00) ? 64'd1 : 64'd0);
    if (er == 2'b00) begin
      chk("mem_ren_slot", 64'(ren_i), 64'(i - 1));
      chk("mem_raddr", ren_addr, a);
    end
    chk("mem_ren_drop", 64'(mem_ren), 64'd0);
    chk("rresp", 64'(rresp), 64'(er));
    chk("rdata", 64'(rdata), 64'(ed));
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_rvalid", 64'(rvalid), 64'd1);
        chk("hold_rdata", 64'(rdata), 64'(ed));
        chk("hold_rresp", 64'(rresp), 64'(er));
        chk("hold_arready", 64'(arready), 64'd0);
      end
      rready = 1'b1;
    end
    @(negedge clk);
    chk("rvalid_clear", 64'(rvalid), 64'd0);
    chk("arready_back", 64'(arready), 64'd1);
    rready = 1'b0;
  endtask

  // arvalid and rready held high: accept spacing and in-order data
  task automatic back_to_back(input logic [63:0] a0, input logic [63:0] a1);
    int          hs_c [2];
    int          n_hs;
    int          n_rsp;
    logic [31:0] got_d [2];
    logic [1:0]  got_r [2];
    bit          hs_now;
    n_hs  = 0;
    n_rsp = 0;
    @(negedge clk);
    arvalid = 1'b1;
    rready  = 1'b1;
    araddr  = a0;
    for (int c = 0; c < 60; c++) begin
      if (rvalid && n_rsp < 2) begin
        got_d[n_rsp] = rdata;
        got_r[n_rsp] = rresp;
        n_rsp++;
      end
      hs_now = arvalid && arready;
      if (hs_now && n_hs < 2) begin
        hs_c[n_hs] = c;
        n_hs++;
      end
      @(negedge clk);
      if (hs_now) begin
        if (n_hs == 1) araddr = a1;
        else arvalid = 1'b0;
      end
      if (n_hs == 2 && n_rsp == 2) break;
    end
    arvalid = 1'b0;
    rready  = 1'b0;
    chk("b2b_accepts", 64'(n_hs), 64'd2);
    chk("b2b_responses", 64'(n_rsp), 64'd2);
    if (n_hs == 2) chk("b2b_spacing", 64'(hs_c[1] - hs_c[0]), 64'(LAT + 3));
    if (n_rsp == 2) begin
      chk("b2b_data0", 64'(got_d[0]), 64'(mem_word(a0)));
      chk("b2b_data1", 64'(got_d[1]), 64'(mem_word(a1)));
      chk("b2b_resp0", 64'(got_r[0]), 64'd0);
      chk("b2b_resp1", 64'(got_r[1]), 64'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] a;
    int          cat;
    bit          seen;
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b1;
    arvalid = 1'b0;
    rready  = 1'b0;
    araddr  = '0;
    for (int w = 0; w < 64; w++) mem[w] = $urandom;
    mem[0] = 32'h0000_0413;

    repeat (2) @(negedge clk);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_mem_ren", 64'(mem_ren), 64'd0);
    chk("rst_mem_raddr", mem_raddr, 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("arready_after_rst", 64'(arready), 64'd1);

    do_read(BASE, 0, 1'b0);
    do_read(BASE + 64'd2, 0, 1'b0);
    do_read(64'h7FFF_FFFC, 0, 1'b0);
    do_read(64'h8800_0000, 0, 1'b0);
    do_read(BASE + SIZE - 64'd4, 0, 1'b0);
    do_read(BASE + 64'd8, 5, 1'b0);
    do_read(BASE + 64'd12, 0, 1'b1);

    back_to_back(BASE, BASE + 64'd4);

    // Reset while a read is waiting for memory
    @(negedge clk);
    arvalid = 1'b1;
    araddr  = BASE + 64'd16;
    for (int k = 0; k < 20 && !arready; k++) @(negedge clk);
    chk("rst_mid_accept", 64'(arready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    rst_n   = 1'b1;
    #1;
    chk("rst_mid_rvalid_now", 64'(rvalid), 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_rvalid", 64'(rvalid), 64'd0);
      chk("rst_mid_arready", 64'(arready), 64'd0);
      chk("rst_mid_mem_ren", 64'(mem_ren), 64'd0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_arready_back", 64'(arready), 64'd1);
    seen = 1'b0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (rvalid) seen = 1'b1;
    end
    chk("rst_mid_no_resp", 64'(seen), 64'd0);
    do_read(BASE + 64'd16, 1, 1'b0);

    // Randomized reads across all decode outcomes
    for (int it = 0; it < 30; it++) begin
      cat = $urandom_range(0, 5);
      case (cat)
        0, 1: a = BASE + 64'($urandom_range(0, 63)) * 64'd4;
        2:    a = BASE + 64'($urandom_range(0, 32'h01FF_FFFF)) * 64'd4;
        3:    a = BASE + 64'($urandom_range(0, 63)) * 64'd4 + 64'($urandom_range(1, 3));
        4:    a = BASE - 64'($urandom_range(1, 1000)) * 64'd4;
        default: a = BASE + SIZE + 64'($urandom_range(0, 1000)) * 64'd4;
      endcase
      do_read(a, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
